// File: rtl/fp_pkg.sv
// Shared floating-point format constants and the normalize-to-round stage record.
package fp_pkg;
    localparam int SIG_BITS = 23;
    localparam int EXP_BITS = 8;
    localparam int BIAS     = (1 << (EXP_BITS - 1)) - 1;
    localparam int EXP_IW   = EXP_BITS + 2;

    // exp holds a two's-complement value; it can be negative after a large left shift.
    typedef struct packed {
        logic                sign;
        logic                zero;
        logic [EXP_IW-1:0]   exp;
        logic [SIG_BITS-1:0] frac;
        logic                guard;
        logic                round;
        logic                sticky;
    } norm_t;
endpackage

// File: rtl/leading_zero_counter.sv
// Combinational leading-zero count; an all-zero input returns WIDTH.
module leading_zero_counter #(
    parameter int  WIDTH = 27,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] din,
    output logic [CNT_W-1:0] count
);

    always_comb begin
        count = CNT_W'(WIDTH);
        // Scanning upward, the highest set bit is the last to overwrite the count.
        for (int i = 0; i < WIDTH; i++) begin
            if (din[i]) count = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/normalize_round.sv
// Two-stage FP adder back end: normalize the raw sum, then round-to-nearest-even and pack.
module normalize_round
    import fp_pkg::norm_t;
#(
    parameter int SIG_BITS = fp_pkg::SIG_BITS,
    parameter int EXP_BITS = fp_pkg::EXP_BITS
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sign,
    input  logic [EXP_BITS-1:0]          in_exp,
    input  logic [SIG_BITS+4:0]          in_sig,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [EXP_BITS+SIG_BITS:0]   out_result,
    output logic [2:0]                   out_flags
);

    localparam int SW = SIG_BITS + 5;
    localparam int LW = SIG_BITS + 4;
    localparam int CW = $clog2(LW + 1);
    localparam int EW = EXP_BITS + 2;
    localparam int RW = 1 + EXP_BITS + SIG_BITS;

    // Returns {overflow, underflow, inexact, sign, exp, frac}.
    function automatic logic [RW+2:0] round_pack(input norm_t n);
        logic signed [EW-1:0] e;
        logic signed [EW-1:0] e_rnd;
        logic [SIG_BITS:0]    frac_rnd;
        logic                 inc;
        logic                 inexact;
        e        = n.exp;
        inexact  = n.guard | n.round | n.sticky;
        inc      = n.guard & (n.round | n.sticky | n.frac[0]);
        frac_rnd = {1'b0, n.frac} + (SIG_BITS + 1)'(inc);
        e_rnd    = e + EW'(frac_rnd[SIG_BITS]);
        if (n.zero)
            round_pack = {3'b000, n.sign, {(EXP_BITS + SIG_BITS){1'b0}}};
        else if (e[EW-1] || e == '0)
            round_pack = {3'b011, n.sign, {(EXP_BITS + SIG_BITS){1'b0}}};
        else if (e_rnd >= EW'((1 << EXP_BITS) - 1))
            round_pack = {3'b101, n.sign, {EXP_BITS{1'b1}}, {SIG_BITS{1'b0}}};
        else
            round_pack = {2'b00, inexact, n.sign, e_rnd[EXP_BITS-1:0], frac_rnd[SIG_BITS-1:0]};
    endfunction

    logic [CW-1:0]        lz_p0;
    logic [LW-1:0]        sh_p0;
    logic signed [EW-1:0] exp_in_p0;
    logic signed [EW-1:0] exp_p0;
    norm_t                norm_p0;

    leading_zero_counter #(.WIDTH(LW)) u_lzc (
        .din   (in_sig[LW-1:0]),
        .count (lz_p0)
    );

    // ---- stage 0 -> 1: normalize ----
    always_comb begin
        exp_in_p0 = {2'b00, in_exp};
        if (in_sig[SW-1]) begin
            sh_p0    = in_sig[SW-1:1];
            sh_p0[0] = in_sig[1] | in_sig[0];
            exp_p0   = exp_in_p0 + EW'(1);
        end else begin
            sh_p0  = in_sig[LW-1:0] << lz_p0;
            exp_p0 = exp_in_p0 - EW'(lz_p0);
        end
        norm_p0.sign   = in_sign;
        norm_p0.zero   = ~sh_p0[LW-1];
        norm_p0.exp    = exp_p0;
        norm_p0.frac   = sh_p0[LW-2:3];
        norm_p0.guard  = sh_p0[2];
        norm_p0.round  = sh_p0[1];
        norm_p0.sticky = sh_p0[0];
    end

    logic          vld_p1;
    logic          vld_p2;
    logic          adv_p2;
    norm_t         norm_p1;
    logic [RW-1:0] result_p2;
    logic [2:0]    flags_p2;

    assign adv_p2   = !vld_p2 || out_ready;
    assign in_ready = !vld_p1 || adv_p2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (in_ready) vld_p1 <= in_valid;
            if (adv_p2)   vld_p2 <= vld_p1;
        end
    end

    // ---- stage 1 -> 2: round and pack ----
    always_ff @(posedge clk) begin
        if (in_valid && in_ready)
            norm_p1 <= norm_p0;
        if (vld_p1 && adv_p2)
            {flags_p2, result_p2} <= round_pack(norm_p1);
    end

    assign out_valid  = vld_p2;
    assign out_result = vld_p2 ? result_p2 : '0;
    assign out_flags  = vld_p2 ? flags_p2 : 3'b000;

endmodule

// File: doc/normalize_round.md
NORMALIZE_ROUND -- requirements
Module: normalize_round

Interface
REQ-001 SHALL have parameter SIG_BITS, default 23, meaning stored fraction width.
REQ-002 SHALL have parameter EXP_BITS, default 8, meaning biased exponent width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  input beat present.
REQ-006 SHALL have port in_ready  output  1  block accepts the beat this cycle.
REQ-007 SHALL have port in_sign  input  1  sign of the raw sum.
REQ-008 SHALL have port in_exp  input  EXP_BITS  biased exponent of the larger operand.
REQ-009 SHALL have port in_sig  input  SIG_BITS+5  raw sum: [SIG_BITS+4] carry, [SIG_BITS+3] hidden, [SIG_BITS+2:3] fraction, [2:0] guard/round/sticky.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port out_result  output  1+EXP_BITS+SIG_BITS  packed IEEE-754 {sign, exp, frac}.
REQ-013 SHALL have port out_flags  output  3  {overflow, underflow, inexact}.

Function
REQ-014 SHALL be a 2-stage pipeline: stage 1 normalize, stage 2 round/pack; latency exactly 2 cycles from accepted input to out_valid with no stall.
REQ-015 Beat transfers only when valid and ready are both high in the same cycle, on either port.
REQ-016 Stage advances when its successor is empty or is transferring that cycle; in_ready = !s1_valid || s1 advancing (combinational from out_ready allowed).
REQ-017 While out_valid and !out_ready, out_result/out_flags SHALL hold stable; no beat lost or reordered.
REQ-018 Stage 1, carry set: right-shift 1, exponent +1, shifted-out bit ORed into sticky.
REQ-019 Stage 1, carry clear: leading-zero count over bits [SIG_BITS+3:0], left-shift until hidden bit is 1, exponent minus count; use signed internal exponent EXP_BITS+2 wide.
REQ-020 in_sig all zero SHALL yield exact zero: exp 0, frac 0, sign = in_sign, flags 000.
REQ-021 Normalized exponent <= 0 (nonzero value) SHALL flush to signed zero, underflow=1, inexact=1; no subnormal output.
REQ-022 Stage 2 SHALL round to nearest even: increment when G && (R || S || lsb).
REQ-023 Rounding carry out of fraction SHALL set frac 0 and exponent +1.
REQ-024 Final exponent >= 2^EXP_BITS-1 SHALL output signed infinity (exp all ones, frac 0), overflow=1, inexact=1.
REQ-025 inexact SHALL equal G|R|S after normalization, or 1 under REQ-021/REQ-024.
REQ-026 in_exp all ones or NaN inputs are out of scope; handled upstream.

Reset
REQ-027 reset_n low SHALL immediately clear both stage valid bits; out_valid=0, out_result=0, out_flags=0, in_ready=1 after release.
REQ-028 Reset mid-operation SHALL discard all in-flight beats; no partial result emitted after release.

Structure
REQ-029 SIG_BITS, EXP_BITS, BIAS and the stage-1-to-stage-2 struct typedef SHALL live in shared package fp_pkg.
REQ-030 Leading-zero count SHALL be sub-module leading_zero_counter (parameterized width, combinational).
REQ-031 Only stage registers are sequential; no multi-cycle iterative shifter.

Verification
REQ-032 in_sig=28'h8000000, in_exp=127, sign 0 -> out_result 32'h40000000, flags 000, out_valid exactly 2 cycles later.
REQ-033 in_sig=28'h0000008, in_exp=127 -> 32'h34000000, flags 000; same with in_exp=1 -> 32'h00000000, flags 011.
REQ-034 RNE tie: {0,1,23'h000001,3'b100}, exp 127 -> 32'h3F800002, inexact 1; {0,1,23'h000000,3'b100} -> 32'h3F800000, inexact 1.
REQ-035 Overflow: {0,1,23'h7FFFFF,3'b110}, exp 254, sign 1 -> 32'hFF800000, flags 101.
REQ-036 Backpressure: 3 back-to-back beats, out_ready low 4 cycles -> in_ready low once both stages full, output held stable, all 3 results in order after release.
REQ-037 Reset mid-flight: reset_n low with 2 beats in flight -> out_valid 0 same cycle; after release, new beat yields only its own result 2 cycles later.
